csr_access_ctrl: RTL and testbench

- Initiator side of the machine-CSR access interface. Accepts a decoded CSR instruction (CSRRW/S/C and immediate forms) and drives the CSR register block's address, read/write, set/clear and write-data signals.
- Samples the returned read data and the illegal-access flag. Hands rd writeback to the register-file write port, or reports an illegal-instruction exception to trap control.
- Sits between the decode stage and the machine-CSR register block.

---
 rtl/csr_access_ctrl_if.sv | 44 ++++
 rtl/csr_access_ctrl.sv | 168 ++++++++++++++++
 tb/tb_csr_access_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/csr_access_ctrl_if.sv
// Bus bundle between decode, the machine-CSR register block, the regfile write port and trap control.
// master = the access controller, slave = everything around it.
interface csr_access_ctrl_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int INSTR_WIDTH    = 32,
    parameter int CSR_ADDR_WIDTH = 12
) ();
    logic                      instr_valid;
    logic [INSTR_WIDTH-1:0]    instr;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic                      instr_ready;
    logic                      flush;
    logic [CSR_ADDR_WIDTH-1:0] csr_addr;
    logic [INSTR_WIDTH-1:0]    instr_dec;
    logic                      mcsr_rd;
    logic                      mcsr_wr;
    logic                      valid_mcsr_rd;
    logic                      valid_mcsr_wr;
    logic                      mcsr_set;
    logic                      mcsr_clr;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [DATA_WIDTH-1:0]     read_data;
    logic                      csr_illegal_access;
    logic                      wb_valid;
    logic [4:0]                wb_rd_idx;
    logic [DATA_WIDTH-1:0]     wb_data;
    logic                      wb_ready;
    logic                      csr_exc_valid;
    logic [INSTR_WIDTH-1:0]    csr_exc_instr;

    modport master (
        input  instr_valid, instr, rs1_data, flush, read_data, csr_illegal_access, wb_ready,
        output instr_ready, csr_addr, instr_dec, mcsr_rd, mcsr_wr, valid_mcsr_rd, valid_mcsr_wr,
               mcsr_set, mcsr_clr, write_data, wb_valid, wb_rd_idx, wb_data,
               csr_exc_valid, csr_exc_instr
    );

    modport slave (
        output instr_valid, instr, rs1_data, flush, read_data, csr_illegal_access, wb_ready,
        input  instr_ready, csr_addr, instr_dec, mcsr_rd, mcsr_wr, valid_mcsr_rd, valid_mcsr_wr,
               mcsr_set, mcsr_clr, write_data, wb_valid, wb_rd_idx, wb_data,
               csr_exc_valid, csr_exc_instr
    );
endinterface

// File: rtl/csr_access_ctrl.sv
// Machine-CSR access initiator: takes one decoded CSR instruction at a time, performs the
// read/modify access on the CSR block, then writes back the old value or raises an exception.
module csr_access_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int INSTR_WIDTH    = 32,
    parameter int CSR_ADDR_WIDTH = 12
) (
    input logic           cpu_clk,
    input logic           cpu_rst,
    csr_access_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        ACCESS = 3'd2,
        WB     = 3'd3,
        EXC    = 3'd4
    } state_t;

    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    state_t                 state_reg, state_next;
    logic [INSTR_WIDTH-1:0] instr_reg;
    logic [DATA_WIDTH-1:0]  operand_reg;
    logic [DATA_WIDTH-1:0]  wb_data_reg;

    // Decode of the instruction currently offered by decode
    logic [2:0] in_funct3;
    logic       in_is_csr;
    logic       accept;

    assign in_funct3 = bus.instr[14:12];
    assign in_is_csr = (bus.instr[6:0] == OPC_SYSTEM) &&
                       (in_funct3 != 3'b000) && (in_funct3 != 3'b100);
    assign accept    = (state_reg == IDLE) && bus.instr_valid;

    // Decode of the held instruction
    logic [2:0] h_funct3;
    logic [4:0] h_rd;
    logic [4:0] h_rs1;
    logic       h_is_rw;
    logic       acc_rd;
    logic       acc_wr;

    assign h_funct3 = instr_reg[14:12];
    assign h_rd     = instr_reg[11:7];
    assign h_rs1    = instr_reg[19:15];
    assign h_is_rw  = (h_funct3[1:0] == 2'b01);
    // RW skips the read when rd is x0; RS/RC skip the write when rs1/uimm is zero
    assign acc_rd   = h_is_rw ? (h_rd != 5'd0) : 1'b1;
    assign acc_wr   = h_is_rw ? 1'b1 : (h_rs1 != 5'd0);

    logic                      instr_ready_next;
    logic [CSR_ADDR_WIDTH-1:0] csr_addr_next;
    logic [INSTR_WIDTH-1:0]    instr_dec_next;
    logic                      mcsr_rd_next;
    logic                      mcsr_wr_next;
    logic                      valid_rd_next;
    logic                      valid_wr_next;
    logic                      mcsr_set_next;
    logic                      mcsr_clr_next;
    logic [DATA_WIDTH-1:0]     write_data_next;
    logic                      wb_valid_next;
    logic [4:0]                wb_rd_idx_next;
    logic [DATA_WIDTH-1:0]     wb_data_next;
    logic                      exc_valid_next;
    logic [INSTR_WIDTH-1:0]    exc_instr_next;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_reg   <= IDLE;
            instr_reg   <= '0;
            operand_reg <= '0;
            wb_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept && in_is_csr) begin
                instr_reg   <= bus.instr;
                operand_reg <= in_funct3[2] ? {{(DATA_WIDTH-5){1'b0}}, bus.instr[19:15]}
                                            : bus.rs1_data;
            end
            if (state_reg == ACCESS)
                wb_data_reg <= bus.read_data;
        end
    end

    always_comb begin
        state_next       = state_reg;
        instr_ready_next = 1'b0;
        csr_addr_next    = '0;
        instr_dec_next   = '0;
        mcsr_rd_next     = 1'b0;
        mcsr_wr_next     = 1'b0;
        valid_rd_next    = 1'b0;
        valid_wr_next    = 1'b0;
        mcsr_set_next    = 1'b0;
        mcsr_clr_next    = 1'b0;
        write_data_next  = '0;
        wb_valid_next    = 1'b0;
        wb_rd_idx_next   = '0;
        wb_data_next     = '0;
        exc_valid_next   = 1'b0;
        exc_instr_next   = '0;

        if ((state_reg == CHECK) || (state_reg == ACCESS)) begin
            csr_addr_next   = instr_reg[31:20];
            instr_dec_next  = instr_reg;
            mcsr_rd_next    = acc_rd;
            mcsr_wr_next    = acc_wr;
            mcsr_set_next   = (h_funct3[1:0] == 2'b10);
            mcsr_clr_next   = (h_funct3[1:0] == 2'b11);
            write_data_next = operand_reg;
        end

        case (state_reg)
            IDLE: begin
                instr_ready_next = 1'b1;
                // Non-CSR encodings are consumed without any effect
                if (bus.instr_valid && in_is_csr)
                    state_next = CHECK;
            end
            CHECK: begin
                if (bus.flush)
                    state_next = IDLE;
                else if (bus.csr_illegal_access)
                    state_next = EXC;
                else
                    state_next = ACCESS;
            end
            ACCESS: begin
                valid_rd_next = acc_rd;
                valid_wr_next = acc_wr;
                state_next    = (acc_rd && (h_rd != 5'd0)) ? WB : IDLE;
            end
            WB: begin
                wb_valid_next  = 1'b1;
                wb_rd_idx_next = h_rd;
                wb_data_next   = wb_data_reg;
                if (bus.wb_ready)
                    state_next = IDLE;
            end
            EXC: begin
                exc_valid_next = 1'b1;
                exc_instr_next = instr_reg;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.instr_ready   = instr_ready_next;
    assign bus.csr_addr      = csr_addr_next;
    assign bus.instr_dec     = instr_dec_next;
    assign bus.mcsr_rd       = mcsr_rd_next;
    assign bus.mcsr_wr       = mcsr_wr_next;
    assign bus.valid_mcsr_rd = valid_rd_next;
    assign bus.valid_mcsr_wr = valid_wr_next;
    assign bus.mcsr_set      = mcsr_set_next;
    assign bus.mcsr_clr      = mcsr_clr_next;
    assign bus.write_data    = write_data_next;
    assign bus.wb_valid      = wb_valid_next;
    assign bus.wb_rd_idx     = wb_rd_idx_next;
    assign bus.wb_data       = wb_data_next;
    assign bus.csr_exc_valid = exc_valid_next;
    assign bus.csr_exc_instr = exc_instr_next;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl: a tiny CSR-block model returns a fixed value when the
// read strobe is high; each step checks the controller outputs a cycle at a time.
module tb_csr_access_ctrl;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic [31:0] csr_value = '0;
    int          checks = 0;
    int          failures = 0;

    always #5 cpu_clk = ~cpu_clk;

    csr_access_ctrl_if bus ();

    assign bus.read_data = bus.valid_mcsr_rd ? csr_value : 32'h0;

    csr_access_ctrl dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .bus     (bus)
    );

    localparam logic [6:0] OPC = 7'b1110011;
    localparam logic [31:0] I_RW5   = {12'h300, 5'd7, 3'b001, 5'd5, OPC}; // csrrw x5,0x300,x7
    localparam logic [31:0] I_RS6   = {12'h301, 5'd0, 3'b010, 5'd6, OPC}; // csrrs x6,0x301,x0
    localparam logic [31:0] I_RCI0  = {12'h304, 5'd8, 3'b111, 5'd0, OPC}; // csrrci x0,0x304,8
    localparam logic [31:0] I_RW1   = {12'h7FF, 5'd2, 3'b001, 5'd1, OPC}; // csrrw x1,0x7ff,x2

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    // Present one instruction for a single cycle; returns with the DUT in its next state
    task automatic offer(input logic [31:0] ins, input logic [31:0] rs1);
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        bus.rs1_data    = rs1;
        tick();
        bus.instr_valid = 1'b0;
        $display("txn instr=0x%08h rs1=0x%08h", ins, rs1);
    endtask

    initial begin
        bus.instr_valid        = 1'b0;
        bus.instr              = '0;
        bus.rs1_data           = '0;
        bus.flush              = 1'b0;
        bus.csr_illegal_access = 1'b0;
        bus.wb_ready           = 1'b1;
        tick();
        tick();
        cpu_rst = 1'b0;
        tick();

        chk("rst_instr_ready", 64'(bus.instr_ready), 64'd1);
        chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("rst_mcsr_rd", 64'(bus.mcsr_rd), 64'd0);
        chk("rst_exc_valid", 64'(bus.csr_exc_valid), 64'd0);
        chk("rst_csr_addr", 64'(bus.csr_addr), 64'd0);

        // CSRRW x5: read+write, old value written back
        csr_value = 32'h80;
        offer(I_RW5, 32'h8);
        chk("rw_chk_mcsr_rd", 64'(bus.mcsr_rd), 64'd1);
        chk("rw_chk_mcsr_wr", 64'(bus.mcsr_wr), 64'd1);
        chk("rw_chk_valid_rd", 64'(bus.valid_mcsr_rd), 64'd0);
        chk("rw_chk_addr", 64'(bus.csr_addr), 64'h300);
        chk("rw_chk_ready", 64'(bus.instr_ready), 64'd0);
        tick();
        chk("rw_acc_valid_rd", 64'(bus.valid_mcsr_rd), 64'd1);
        chk("rw_acc_valid_wr", 64'(bus.valid_mcsr_wr), 64'd1);
        chk("rw_acc_wdata", 64'(bus.write_data), 64'h8);
        chk("rw_acc_set", 64'(bus.mcsr_set), 64'd0);
        chk("rw_acc_clr", 64'(bus.mcsr_clr), 64'd0);
        chk("rw_acc_instr_dec", 64'(bus.instr_dec), 64'(I_RW5));
        tick();
        chk("rw_wb_valid", 64'(bus.wb_valid), 64'd1);
        chk("rw_wb_idx", 64'(bus.wb_rd_idx), 64'd5);
        chk("rw_wb_data", 64'(bus.wb_data), 64'h80);
        tick();
        chk("rw_done_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("rw_done_ready", 64'(bus.instr_ready), 64'd1);

        // CSRRS x6 with rs1=x0: read only
        csr_value = 32'h4000_0100;
        offer(I_RS6, 32'hDEAD_BEEF);
        chk("rs_chk_mcsr_wr", 64'(bus.mcsr_wr), 64'd0);
        chk("rs_chk_set", 64'(bus.mcsr_set), 64'd1);
        tick();
        chk("rs_acc_valid_rd", 64'(bus.valid_mcsr_rd), 64'd1);
        chk("rs_acc_valid_wr", 64'(bus.valid_mcsr_wr), 64'd0);
        chk("rs_acc_wdata", 64'(bus.write_data), 64'hDEAD_BEEF);
        tick();
        chk("rs_wb_idx", 64'(bus.wb_rd_idx), 64'd6);
        chk("rs_wb_data", 64'(bus.wb_data), 64'h4000_0100);
        tick();

        // CSRRCI x0, uimm=8: clear with immediate operand, no writeback
        offer(I_RCI0, 32'hFFFF_FFFF);
        chk("rci_chk_clr", 64'(bus.mcsr_clr), 64'd1);
        chk("rci_chk_set", 64'(bus.mcsr_set), 64'd0);
        tick();
        chk("rci_acc_wdata", 64'(bus.write_data), 64'h8);
        chk("rci_acc_valid_wr", 64'(bus.valid_mcsr_wr), 64'd1);
        tick();
        chk("rci_end_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("rci_end_ready", 64'(bus.instr_ready), 64'd1);

        // CSRRW x1 to a non-existent CSR: exception, no strobes
        offer(I_RW1, 32'h1);
        bus.csr_illegal_access = 1'b1;
        tick();
        bus.csr_illegal_access = 1'b0;
        chk("ill_exc_valid", 64'(bus.csr_exc_valid), 64'd1);
        chk("ill_exc_instr", 64'(bus.csr_exc_instr), 64'(I_RW1));
        chk("ill_valid_rd", 64'(bus.valid_mcsr_rd), 64'd0);
        chk("ill_valid_wr", 64'(bus.valid_mcsr_wr), 64'd0);
        tick();
        chk("ill_end_exc_valid", 64'(bus.csr_exc_valid), 64'd0);
        chk("ill_end_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("ill_end_ready", 64'(bus.instr_ready), 64'd1);

        // Back-pressure in WB with a flush pulse that must be ignored
        csr_value    = 32'h1234;
        bus.wb_ready = 1'b0;
        offer(I_RW5, 32'h55);
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.flush = (i == 1);
            tick();
            chk("bp_wb_valid", 64'(bus.wb_valid), 64'd1);
            chk("bp_wb_data", 64'(bus.wb_data), 64'h1234);
            chk("bp_ready", 64'(bus.instr_ready), 64'd0);
        end
        bus.flush    = 1'b0;
        bus.wb_ready = 1'b1;
        tick();
        chk("bp_end_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("bp_end_ready", 64'(bus.instr_ready), 64'd1);

        // Flush in CHECK: back to IDLE with no access
        offer(I_RW5, 32'h77);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("fl_ready", 64'(bus.instr_ready), 64'd1);
        chk("fl_valid_rd", 64'(bus.valid_mcsr_rd), 64'd0);
        chk("fl_valid_wr", 64'(bus.valid_mcsr_wr), 64'd0);
        tick();
        chk("fl_next_valid_wr", 64'(bus.valid_mcsr_wr), 64'd0);

        // Reset during WB discards the pending writeback
        csr_value    = 32'hABCD;
        bus.wb_ready = 1'b0;
        offer(I_RW5, 32'h9);
        tick();
        tick();
        chk("rwb_wb_valid_before", 64'(bus.wb_valid), 64'd1);
        cpu_rst = 1'b1;
        tick();
        cpu_rst      = 1'b0;
        bus.wb_ready = 1'b1;
        chk("rwb_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("rwb_ready", 64'(bus.instr_ready), 64'd1);
        chk("rwb_wb_data", 64'(bus.wb_data), 64'd0);

        // Non-CSR opcode: consumed and dropped
        offer(32'h0000_0013, 32'h0);
        chk("nc_ready", 64'(bus.instr_ready), 64'd1);
        chk("nc_mcsr_rd", 64'(bus.mcsr_rd), 64'd0);
        chk("nc_mcsr_wr", 64'(bus.mcsr_wr), 64'd0);
        tick();
        chk("nc_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("nc_exc_valid", 64'(bus.csr_exc_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
